// File: rtl/serial_rb_pkg.sv
// Shared types and sizing helpers for the serial register-bank loader.
package serial_rb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      CHECK   = 3'd2,
      WAIT_HI = 3'd3,
      DONE    = 3'd4
   } rb_state_e;

   localparam int MAX_FL = 64;
   localparam int CNT_W  = $clog2(MAX_FL) + 1;

   function automatic int frame_len(input int aw, input int dw, input int parity);
      return aw + dw + ((parity != 0) ? 1 : 0);
   endfunction

endpackage

// File: rtl/serial_frame_shifter.sv
// MSB-first frame capture: address/data payload register, bit counter and running parity.
module serial_frame_shifter
   import serial_rb_pkg::*;
#(
   parameter int AW     = 3,
   parameter int DW     = 18,
   parameter int PARITY = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          shift,
   input  logic          sd,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data,
   output logic          par,
   output logic          last,
   output logic          full
);

   localparam int FL = frame_len(AW, DW, PARITY);
   localparam int PW = AW + DW;
   localparam logic [CNT_W-1:0] FL_C   = CNT_W'(FL);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FL - 1);
   localparam logic [CNT_W-1:0] PW_C   = CNT_W'(PW);

   logic [PW-1:0]    sr;
   logic [CNT_W-1:0] cnt;

   // The trailing parity bit only feeds the running parity; it never enters the payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= {{AW{1'b1}}, {DW{1'b0}}};
         cnt <= '0;
         par <= 1'b0;
      end else if (start) begin
         sr  <= {sr[PW-2:0], sd};
         cnt <= CNT_W'(1);
         par <= sd;
      end else if (shift) begin
         if (cnt < PW_C) sr <= {sr[PW-2:0], sd};
         cnt <= cnt + CNT_W'(1);
         par <= par ^ sd;
      end
   end

   assign addr = sr[PW-1 -: AW];
   assign data = sr[DW-1:0];
   assign last = (cnt == LAST_C);
   assign full = (cnt == FL_C);

endmodule

// File: rtl/serial_rb_loader.sv
// Serial frame receiver driving single-cycle register-bank writes, with error
// counting and a done flag once every bank address has been written.
module serial_rb_loader
   import serial_rb_pkg::*;
#(
   parameter int AW     = 3,
   parameter int DW     = 18,
   parameter int PARITY = 1,
   parameter int ECW    = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sen,
   input  logic           sd,
   output logic           RB_RW,
   output logic [AW-1:0]  RB_A,
   output logic [DW-1:0]  RB_D,
   output logic           done,
   output logic           frame_err,
   output logic           par_err,
   output logic [ECW-1:0] err_cnt
);

   localparam int NB = 2 ** AW;

   rb_state_e      state;
   logic [NB-1:0]  written;
   logic [NB-1:0]  written_nxt;
   logic           start, shift, par, last, full, good;

   assign start = (state == IDLE)  && !sen;
   assign shift = (state == SHIFT) && !sen;

   serial_frame_shifter #(
      .AW     (AW),
      .DW     (DW),
      .PARITY (PARITY)
   ) u_shifter (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .shift (shift),
      .sd    (sd),
      .addr  (RB_A),
      .data  (RB_D),
      .par   (par),
      .last  (last),
      .full  (full)
   );

   // Parity over the whole frame, evaluated at the edge that captures its last bit.
   assign good        = (PARITY == 0) || !(par ^ sd);
   assign written_nxt = written | (NB'(1) << RB_A);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         written   <= '0;
         RB_RW     <= 1'b1;
         done      <= 1'b0;
         frame_err <= 1'b0;
         par_err   <= 1'b0;
         err_cnt   <= '0;
      end else begin
         RB_RW     <= 1'b1;
         frame_err <= 1'b0;
         par_err   <= 1'b0;
         if ((frame_err || par_err) && !(&err_cnt)) err_cnt <= err_cnt + ECW'(1);

         case (state)
            IDLE: if (!sen) state <= SHIFT;
            SHIFT: begin
               if (sen) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else if (last) begin
                  RB_RW   <= ~good;
                  par_err <= ~good;
                  state   <= CHECK;
               end
            end
            CHECK: begin
               if (!RB_RW && full) written <= written_nxt;
               if (!RB_RW && full && (&written_nxt)) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (!sen) begin
                  state <= WAIT_HI;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_HI: if (sen) state <= IDLE;
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_rb_loader.sv
// Randomised bench for serial_rb_loader against a frame-level reference model.
module tb_serial_rb_loader;

   localparam int AW = 3, DW = 18, PARITY = 1, ECW = 8, FL = 22;

   typedef struct {
      int              cyc;
      logic [AW-1:0]   a;
      logic [DW-1:0]   d;
   } wr_t;

   logic           clk = 1'b0;
   logic           rst, sen, sd;
   logic           RB_RW, done, frame_err, par_err;
   logic [AW-1:0]  RB_A;
   logic [DW-1:0]  RB_D;
   logic [ECW-1:0] err_cnt;

   int n_chk = 0, n_err = 0, cyc = 0;
   int pe_seen = 0, fe_seen = 0, pe_exp = 0, fe_exp = 0;
   int err_mod = 0;
   logic [7:0] w_mod = '0;
   bit done_mod = 0;
   wr_t wq[$], eq[$];

   serial_rb_loader #(.AW(AW), .DW(DW), .PARITY(PARITY), .ECW(ECW)) dut (
      .clk(clk), .rst(rst), .sen(sen), .sd(sd), .RB_RW(RB_RW), .RB_A(RB_A),
      .RB_D(RB_D), .done(done), .frame_err(frame_err), .par_err(par_err),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!RB_RW) wq.push_back('{cyc: cyc, a: RB_A, d: RB_D});
      if (par_err) pe_seen++;
      if (frame_err) fe_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " RB_RW"}, 32'(RB_RW), 1);
      chk({tag, " RB_A"}, 32'(RB_A), 7);
      chk({tag, " RB_D"}, 32'(RB_D), 0);
      chk({tag, " done"}, 32'(done), 0);
      chk({tag, " frame_err"}, 32'(frame_err), 0);
      chk({tag, " par_err"}, 32'(par_err), 0);
      chk({tag, " err_cnt"}, 32'(err_cnt), 0);
   endtask

   // Drive one frame: nbits of it (FL = complete), extra bits with sen still low, then gap idle edges.
   task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit flip,
                       input int nbits, input int extra, input int gap);
      logic [FL-1:0] fr;
      int c0;
      fr = {a, d, (^{a, d}) ^ flip};
      c0 = 0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk); sen = 1'b0; sd = fr[FL-1-i];
         if (i == 0) c0 = cyc + 1;
      end
      for (int i = 0; i < extra; i++) begin
         @(negedge clk); sen = 1'b0; sd = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < gap; i++) begin
         @(negedge clk); sen = 1'b1; sd = 1'($urandom_range(0, 1));
      end
      if (!done_mod) begin
         if (nbits < FL) begin
            fe_exp++;
            if (err_mod < 255) err_mod++;
         end else if (flip) begin
            pe_exp++;
            if (err_mod < 255) err_mod++;
         end else begin
            eq.push_back('{cyc: c0 + FL - 1, a: a, d: d});
            w_mod[a] = 1'b1;
            if (w_mod == 8'hFF) done_mod = 1;
         end
      end
   endtask

   task automatic settle(input string tag);
      wr_t w, e;
      repeat (4) begin @(negedge clk); sen = 1'b1; end
      while (eq.size() > 0) begin
         e = eq.pop_front();
         if (wq.size() == 0) chk({tag, " missing write"}, 0, 1);
         else begin
            w = wq.pop_front();
            chk({tag, " wr addr"}, 32'(w.a), 32'(e.a));
            chk({tag, " wr data"}, 32'(w.d), 32'(e.d));
            chk({tag, " wr cycle"}, w.cyc, e.cyc);
         end
      end
      chk({tag, " extra writes"}, wq.size(), 0);
      wq.delete();
      chk({tag, " par_err pulses"}, pe_seen, pe_exp);
      chk({tag, " frame_err pulses"}, fe_seen, fe_exp);
      chk({tag, " err_cnt"}, 32'(err_cnt), err_mod);
      chk({tag, " done"}, 32'(done), 32'(done_mod));
      chk({tag, " RB_RW idle"}, 32'(RB_RW), 1);
   endtask

   task automatic reset_dut(input string tag);
      @(negedge clk); rst = 1'b1; sen = 1'b1;
      @(negedge clk); chk_reset(tag);
      rst = 1'b0;
      w_mod = '0; err_mod = 0; done_mod = 0;
      eq.delete(); wq.delete();
   endtask

   initial begin
      rst = 1'b1; sen = 1'b1; sd = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("por");
      rst = 1'b0;

      // In-order fill, back-to-back with one idle edge
      for (int a = 0; a < 8; a++) send(AW'(a), 18'h2A5A5 + DW'(a), 0, FL, 0, 1);
      settle("inorder");
      send(3'd2, 18'h11111, 0, FL, 0, 1);
      settle("in_done");

      // Address 7 first: done only after the final write
      reset_dut("rst1");
      send(3'd7, 18'h2A5AC, 0, FL, 0, 1);
      settle("a7first");
      for (int a = 0; a < 7; a++) begin
         send(AW'(a), 18'h2A5A5 + DW'(a), 0, FL, 0, 1);
         settle("a7rest");
      end

      // Bad parity on addr 3, then resend
      reset_dut("rst2");
      for (int a = 0; a < 8; a++) send(AW'(a), 18'h2A5A5 + DW'(a), (a == 3), FL, 0, 1);
      settle("badpar");
      send(3'd3, 18'h2A5A8, 0, FL, 0, 1);
      settle("resend3");

      // Short frame, then a good frame; then a 30-bit frame
      reset_dut("rst3");
      send(3'd5, 18'h3FFFF, 0, 10, 0, 1);
      send(3'd5, 18'h12345, 0, FL, 0, 1);
      settle("short");
      send(3'd6, 18'h0F0F0, 0, FL, 8, 1);
      settle("long");

      // Random mix of good, bad-parity, short and over-long frames
      reset_dut("rst4");
      for (int n = 0; n < 60; n++) begin
         int mode;
         mode = $urandom_range(0, 9);
         send(AW'($urandom_range(0, 7)), DW'($urandom), (mode == 8),
              (mode == 9) ? $urandom_range(1, FL - 1) : FL,
              (mode < 8) ? $urandom_range(0, 3) : 0, $urandom_range(1, 3));
         if (n % 5 == 4) settle("rand");
      end
      settle("rand_end");

      // Reset after 5 bits of a frame
      for (int i = 0; i < 5; i++) begin @(negedge clk); sen = 1'b0; sd = 1'($urandom_range(0, 1)); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); chk_reset("midrst");
      rst = 1'b0; sen = 1'b1;
      w_mod = '0; err_mod = 0; done_mod = 0; eq.delete(); wq.delete();
      settle("midrst_after");

      // Error counter saturation
      for (int n = 0; n < 259; n++) send(AW'($urandom_range(0, 7)), DW'($urandom), 0, 2, 0, 1);
      settle("sat");
      chk("sat value", 32'(err_cnt), 255);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
